// File: rtl/csr_access_unit_pkg.sv
// Shared widths, write-enable levels, Zicsr funct3 encodings and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csr_access_unit_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int CSR_ADDR_WIDTH = 12;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_READ   = 2'b01,
        ST_COMMIT = 2'b10
    } state_e;

endpackage

// File: rtl/csr_access_unit_alu.sv
// Computes the new CSR value, the write-suppression decision and the illegal flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module csr_alu
    import csr_access_unit_pkg::*;
#(
    parameter int DATA_W     = DATA_WIDTH,
    parameter int CSR_ADDR_W = CSR_ADDR_WIDTH,
    parameter int REG_ADDR_W = REG_ADDR_WIDTH
) (
    input  logic [2:0]            funct3_i,
    input  logic [CSR_ADDR_W-1:0] csr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_idx_i,
    input  logic [DATA_W-1:0]     old_i,
    input  logic [DATA_W-1:0]     src_i,
    output logic [DATA_W-1:0]     new_o,
    output logic                  csr_we_o,
    output logic                  illegal_o
);

    logic set_clr;
    logic bad_op;
    logic suppress;
    logic read_only;

    // Decode the operation: new value, and whether the set/clear form touches the CSR at all.
    always_comb begin
        new_o   = old_i;
        set_clr = 1'b0;
        bad_op  = 1'b0;
        case (funct3_i)
            F3_CSRRW, F3_CSRRWI: new_o = src_i;
            F3_CSRRS, F3_CSRRSI: begin
                new_o   = old_i | src_i;
                set_clr = 1'b1;
            end
            F3_CSRRC, F3_CSRRCI: begin
                new_o   = old_i & ~src_i;
                set_clr = 1'b1;
            end
            default: bad_op = 1'b1;
        endcase
    end

    // Set/clear with x0/zimm=0 is a pure read; a read of a read-only CSR is therefore legal.
    always_comb begin
        suppress  = set_clr && (rs1_idx_i == '0);
        read_only = (csr_addr_i[CSR_ADDR_W-1 -: 2] == 2'b11);
        illegal_o = bad_op || (read_only && !suppress);
        csr_we_o  = (suppress || illegal_o) ? WRITE_DISABLE : WRITE_ENABLE;
    end

endmodule

// File: rtl/csr_access_unit.sv
// Runs one Zicsr instruction: read old CSR, compute new, write CSR and rd.
// Latency: accept -> READ -> COMMIT, done pulses in the 3rd cycle counting the accept cycle.
// Backpressure: req_ready only in IDLE; one instruction per 3 cycles at most.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int DATA_W     = DATA_WIDTH,
    parameter int CSR_ADDR_W = CSR_ADDR_WIDTH,
    parameter int REG_ADDR_W = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [CSR_ADDR_W-1:0] req_csr_addr,
    input  logic [REG_ADDR_W-1:0] req_rs1_idx,
    input  logic [DATA_W-1:0]     req_rs1_data,
    input  logic [REG_ADDR_W-1:0] req_rd,
    input  logic                  flush,
    output logic [CSR_ADDR_W-1:0] csr_raddr,
    input  logic [DATA_W-1:0]     csr_rdata,
    output logic                  csr_we,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0]     csr_wdata,
    output logic                  rd_we,
    output logic [REG_ADDR_W-1:0] rd_waddr,
    output logic [DATA_W-1:0]     rd_wdata,
    output logic                  done,
    output logic                  illegal
);

    state_e state_q, state_d;

    logic [2:0]            funct3_q;
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [REG_ADDR_W-1:0] rs1_idx_q;
    logic [DATA_W-1:0]     rs1_data_q;
    logic [REG_ADDR_W-1:0] rd_q;

    logic [CSR_ADDR_W-1:0] csr_waddr_q;
    logic [DATA_W-1:0]     csr_wdata_q;
    logic [REG_ADDR_W-1:0] rd_waddr_q;
    logic [DATA_W-1:0]     rd_wdata_q;
    logic                  csr_we_q;
    logic                  rd_we_q;
    logic                  illegal_q;

    logic                  accept;
    logic                  capture;
    logic [DATA_W-1:0]     src;
    logic [DATA_W-1:0]     alu_new;
    logic                  alu_we;
    logic                  alu_illegal;

    // Immediate forms take rs1_idx as a zero-extended 5-bit zimm.
    assign src = funct3_q[2] ? {{(DATA_W-REG_ADDR_W){1'b0}}, rs1_idx_q} : rs1_data_q;

    csr_alu #(
        .DATA_W     (DATA_W),
        .CSR_ADDR_W (CSR_ADDR_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_alu (
        .funct3_i   (funct3_q),
        .csr_addr_i (addr_q),
        .rs1_idx_i  (rs1_idx_q),
        .old_i      (csr_rdata),
        .src_i      (src),
        .new_o      (alu_new),
        .csr_we_o   (alu_we),
        .illegal_o  (alu_illegal)
    );

    // State register; reset aborts any in-flight instruction before it can commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and COMMIT-only strobes; flush is honoured in IDLE and READ, never in COMMIT.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        csr_we    = WRITE_DISABLE;
        rd_we     = WRITE_DISABLE;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    capture = 1'b1;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                csr_we  = csr_we_q;
                rd_we   = rd_we_q;
                done    = 1'b1;
                illegal = illegal_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields latched on accept; result registers loaded on the READ->COMMIT edge
    // so the write-side outputs stay stable until the next instruction reaches COMMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            funct3_q    <= '0;
            addr_q      <= '0;
            rs1_idx_q   <= '0;
            rs1_data_q  <= '0;
            rd_q        <= '0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            rd_waddr_q  <= '0;
            rd_wdata_q  <= '0;
            csr_we_q    <= WRITE_DISABLE;
            rd_we_q     <= WRITE_DISABLE;
            illegal_q   <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q   <= req_funct3;
                addr_q     <= req_csr_addr;
                rs1_idx_q  <= req_rs1_idx;
                rs1_data_q <= req_rs1_data;
                rd_q       <= req_rd;
            end
            if (capture) begin
                csr_waddr_q <= addr_q;
                csr_wdata_q <= alu_new;
                rd_waddr_q  <= rd_q;
                rd_wdata_q  <= csr_rdata;
                csr_we_q    <= alu_we;
                rd_we_q     <= (rd_q != REG_ADDR_W'(ZERO_REG)) && !alu_illegal;
                illegal_q   <= alu_illegal;
            end
        end
    end

    assign csr_raddr = addr_q;
    assign csr_waddr = csr_waddr_q;
    assign csr_wdata = csr_wdata_q;
    assign rd_waddr  = rd_waddr_q;
    assign rd_wdata  = rd_wdata_q;

endmodule
